// File: rtl/arm_defs_pkg.sv
// arm_defs -- shared encodings for the execute-stage controller.
//   * ARM data-processing opcodes and condition codes
//   * ALU command encoding driven on exec_command
//   * controller FSM state type
//   * decode_op(): opcode -> ALU command, write-back and flag class
package arm_defs;

  // ARM data-processing opcodes (instruction bits 24:21)
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ALU command encoding
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } exe_state_t;

  // Which status flags an instruction may write
  typedef enum logic [1:0] {
    FLG_NONE = 2'd0,
    FLG_NZ   = 2'd1,
    FLG_NZCV = 2'd2
  } flag_class_t;

  typedef struct packed {
    logic [3:0]  cmd;     // ALU command
    logic        wb;      // writes a register result
    flag_class_t flags;   // flags affected when an update happens
    logic        forced;  // compare/test: updates flags without S bit
  } op_decode_t;

  function automatic op_decode_t decode_op(input logic [3:0] op);
    op_decode_t d;
    d = '{cmd: CMD_NOP, wb: 1'b0, flags: FLG_NONE, forced: 1'b0};
    case (op)
      OP_MOV: d = '{cmd: CMD_MOV, wb: 1'b1, flags: FLG_NZ,   forced: 1'b0};
      OP_MVN: d = '{cmd: CMD_MVN, wb: 1'b1, flags: FLG_NZ,   forced: 1'b0};
      OP_ADD: d = '{cmd: CMD_ADD, wb: 1'b1, flags: FLG_NZCV, forced: 1'b0};
      OP_ADC: d = '{cmd: CMD_ADC, wb: 1'b1, flags: FLG_NZCV, forced: 1'b0};
      OP_SUB: d = '{cmd: CMD_SUB, wb: 1'b1, flags: FLG_NZCV, forced: 1'b0};
      OP_SBC: d = '{cmd: CMD_SBC, wb: 1'b1, flags: FLG_NZCV, forced: 1'b0};
      OP_AND: d = '{cmd: CMD_AND, wb: 1'b1, flags: FLG_NZ,   forced: 1'b0};
      OP_ORR: d = '{cmd: CMD_ORR, wb: 1'b1, flags: FLG_NZ,   forced: 1'b0};
      OP_EOR: d = '{cmd: CMD_EOR, wb: 1'b1, flags: FLG_NZ,   forced: 1'b0};
      OP_CMP: d = '{cmd: CMD_SUB, wb: 1'b0, flags: FLG_NZCV, forced: 1'b1};
      OP_TST: d = '{cmd: CMD_AND, wb: 1'b0, flags: FLG_NZ,   forced: 1'b1};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check -- evaluates an ARM condition field against {N,Z,C,V}.
//   cond   in  [3:0]  condition field
//   status in  [3:0]  {N,Z,C,V}
//   pass   out        instruction may execute
module cond_check
  import arm_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;

  assign n = status[3];
  assign z = status[2];
  assign c = status[1];
  assign v = status[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // 1111: never
    endcase
  end

endmodule

// File: rtl/exe_ctrl.sv
// exe_ctrl -- execute-stage controller between ID and MEM.
// Holds one decoded instruction, drives the ALU command, qualifies the
// write-back / memory controls by the condition code and owns the
// {N,Z,C,V} status register.
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready                handshake from ID
//   cond, opcode, s_bit              instruction fields
//   mem_r_in, mem_w_in               LDR / STR indication
//   flush                            drop held instruction (branch taken)
//   alu_n/z/c/v                      flags from the combinational ALU
//   exec_command, carry_in           ALU control
//   out_valid/out_ready              handshake to MEM
//   wb_en, mem_r_en, mem_w_en        qualified controls to MEM
//   status                           current {N,Z,C,V}
module exe_ctrl
  import arm_defs::*;
#(
  parameter logic [3:0] SR_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] cond,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  input  logic       mem_r_in,
  input  logic       mem_w_in,
  input  logic       flush,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic [3:0] exec_command,
  output logic       carry_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       wb_en,
  output logic       mem_r_en,
  output logic       mem_w_en,
  output logic [3:0] status
);

  exe_state_t state_reg, state_next;

  logic [3:0] cond_reg;
  logic [3:0] opcode_reg;
  logic       s_bit_reg;
  logic       mem_r_reg;
  logic       mem_w_reg;
  logic [3:0] status_reg;
  logic [3:0] status_next;

  logic       handshake;
  logic       accept;
  logic       retire;
  logic       cond_pass;
  logic       mem_op;
  logic       flag_update;
  logic [3:0] flag_mask;
  logic [3:0] alu_flags;
  op_decode_t dec;

  assign out_valid = (state_reg != ST_IDLE);
  assign handshake = out_valid & out_ready;
  // A flush cycle and reset cycles take nothing new from ID.
  assign in_ready  = ~rst & ~flush & ((state_reg == ST_IDLE) | handshake);
  assign accept    = in_valid & in_ready;
  // A flush wins over a coinciding handshake: the instruction is dropped.
  assign retire    = handshake & ~flush;

  assign mem_op    = mem_r_reg | mem_w_reg;
  assign dec       = decode_op(opcode_reg);
  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};
  assign status    = status_reg;
  assign carry_in  = status_reg[1];

  cond_check u_cond_check (
    .cond   (cond_reg),
    .status (status_reg),
    .pass   (cond_pass)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) state_next = ST_ISSUE;
        end
        ST_ISSUE, ST_HOLD: begin
          if (out_ready) begin
            state_next = accept ? ST_ISSUE : ST_IDLE;
          end else begin
            state_next = ST_HOLD;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- held instruction ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_reg   <= COND_NV;
      opcode_reg <= 4'b0000;
      s_bit_reg  <= 1'b0;
      mem_r_reg  <= 1'b0;
      mem_w_reg  <= 1'b0;
    end else if (accept) begin
      cond_reg   <= cond;
      opcode_reg <= opcode;
      s_bit_reg  <= s_bit;
      mem_r_reg  <= mem_r_in;
      mem_w_reg  <= mem_w_in;
    end
  end

  // ---------------- qualified outputs ----------------
  // Everything derives from held registers and the status register, which
  // only changes at a handshake, so outputs stay constant while holding.
  always_comb begin
    exec_command = CMD_NOP;
    wb_en        = 1'b0;
    mem_r_en     = 1'b0;
    mem_w_en     = 1'b0;
    if (out_valid && cond_pass) begin
      if (mem_op) begin
        // address generation for LDR/STR uses the adder
        exec_command = CMD_ADD;
        wb_en        = mem_r_reg;
        mem_r_en     = mem_r_reg;
        mem_w_en     = mem_w_reg;
      end else begin
        exec_command = dec.cmd;
        wb_en        = dec.wb;
      end
    end
  end

  // ---------------- status register ----------------
  assign flag_update = retire & cond_pass & ~mem_op & (s_bit_reg | dec.forced);

  always_comb begin
    flag_mask = 4'b0000;
    case (dec.flags)
      FLG_NZ:   flag_mask = 4'b1100;
      FLG_NZCV: flag_mask = 4'b1111;
      default:  flag_mask = 4'b0000;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign status_next[gi] = (flag_update && flag_mask[gi]) ? alu_flags[gi]
                                                               : status_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg <= SR_RESET;
    end else begin
      status_reg <= status_next;
    end
  end

endmodule

// File: tb/tb_exe_ctrl.sv
// tb_exe_ctrl -- directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the execute controller.
module tb_exe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cond;
  logic [3:0] opcode;
  logic       s_bit;
  logic       mem_r_in;
  logic       mem_w_in;
  logic       flush;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic [3:0] exec_command;
  logic       carry_in;
  logic       out_valid;
  logic       out_ready;
  logic       wb_en, mem_r_en, mem_w_en;
  logic [3:0] status;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  exe_ctrl #(.SR_RESET(4'b0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cond         (cond),
    .opcode       (opcode),
    .s_bit        (s_bit),
    .mem_r_in     (mem_r_in),
    .mem_w_in     (mem_w_in),
    .flush        (flush),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .exec_command (exec_command),
    .carry_in     (carry_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .status       (status)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (one-slot instruction buffer) ----------
  logic       m_valid;
  logic [3:0] m_cond, m_op, m_sr;
  logic       m_s, m_mr, m_mw;

  function automatic logic m_cond_ok(input logic [3:0] c, input logic [3:0] sr);
    logic n, z, cf, v;
    {n, z, cf, v} = sr;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_cmd(input logic [3:0] op);
    case (op)
      4'b1101: return 4'b0001;
      4'b1111: return 4'b1001;
      4'b0100: return 4'b0010;
      4'b0101: return 4'b0011;
      4'b0010: return 4'b0100;
      4'b0110: return 4'b0101;
      4'b0000: return 4'b0110;
      4'b1100: return 4'b0111;
      4'b0001: return 4'b1000;
      4'b1010: return 4'b0100;
      4'b1000: return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic m_is_arith(input logic [3:0] op);
    return op == 4'b0100 || op == 4'b0101 || op == 4'b0010 ||
           op == 4'b0110 || op == 4'b1010;
  endfunction

  function automatic logic m_is_cmp_tst(input logic [3:0] op);
    return op == 4'b1010 || op == 4'b1000;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Compare the DUT against the model, then advance the model through the
  // coming clock edge with the inputs currently applied.
  task automatic cyc();
    logic pass, mem, e_wb;
    logic [3:0] e_cmd;
    #1;
    mem  = m_mr || m_mw;
    pass = m_valid && m_cond_ok(m_cond, m_sr);
    e_cmd = !pass ? 4'b0000 : (mem ? 4'b0010 : m_cmd(m_op));
    e_wb  = pass && (mem ? m_mr : (m_cmd(m_op) != 4'b0000 && !m_is_cmp_tst(m_op)));
    chk("m_in_ready",  {3'b0, in_ready},  {3'b0, !rst && !flush && (!m_valid || out_ready)});
    chk("m_out_valid", {3'b0, out_valid}, {3'b0, m_valid});
    chk("m_exec_cmd",  exec_command, e_cmd);
    chk("m_wb_en",     {3'b0, wb_en},    {3'b0, e_wb});
    chk("m_mem_r_en",  {3'b0, mem_r_en}, {3'b0, pass && m_mr});
    chk("m_mem_w_en",  {3'b0, mem_w_en}, {3'b0, pass && m_mw});
    chk("m_carry_in",  {3'b0, carry_in}, {3'b0, m_sr[1]});
    chk("m_status",    status, m_sr);
    if (rst) begin
      m_valid = 1'b0;
      m_sr    = 4'b0000;
    end else if (flush) begin
      m_valid = 1'b0;
    end else begin
      logic acc;
      acc = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) begin
        if (pass && !mem && (m_s || m_is_cmp_tst(m_op))) begin
          if (m_is_arith(m_op))
            m_sr = {alu_n, alu_z, alu_c, alu_v};
          else if (m_cmd(m_op) != 4'b0000)
            m_sr = {alu_n, alu_z, m_sr[1:0]};
        end
        m_valid = 1'b0;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_cond = cond; m_op = opcode; m_s = s_bit; m_mr = mem_r_in; m_mw = mem_w_in;
      end
    end
    @(negedge clk);
    cycle++;
  endtask

  // Offer one instruction from IDLE; returns with it in the issue slot.
  task automatic send(input logic [3:0] c, input logic [3:0] op, input logic s,
                      input logic mr, input logic mw, input logic ordy,
                      input logic [3:0] alu);
    in_valid = 1'b1; cond = c; opcode = op; s_bit = s;
    mem_r_in = mr; mem_w_in = mw; out_ready = ordy;
    {alu_n, alu_z, alu_c, alu_v} = alu;
    cyc();
    in_valid = 1'b0;
  endtask

  localparam logic [3:0] AL = 4'b1110, NE = 4'b0001;
  localparam logic [3:0] ADD = 4'b0100, ADC = 4'b0101, SUB = 4'b0010;
  localparam logic [3:0] MOV = 4'b1101, CMP = 4'b1010, AND_OP = 4'b0000;

  initial begin
    rst = 1'b1; in_valid = 0; cond = 0; opcode = 0; s_bit = 0;
    mem_r_in = 0; mem_w_in = 0; flush = 0; out_ready = 0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    m_valid = 0; m_sr = 4'b0000; m_cond = 0; m_op = 0; m_s = 0; m_mr = 0; m_mw = 0;
    repeat (2) @(negedge clk);

    // reset
    cyc();
    chk("rst_in_ready", {3'b0, in_ready}, 4'd0);
    rst = 1'b0;
    cyc();
    chk("rst_status", status, 4'b0000);
    chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
    chk("rst_exec", exec_command, 4'b0000);

    // SUBS AL: command one cycle after accept, flags N=1 afterwards
    send(AL, SUB, 1, 0, 0, 1, 4'b1000);
    chk("subs_exec", exec_command, 4'b0100);
    chk("subs_valid", {3'b0, out_valid}, 4'd1);
    cyc();
    chk("subs_status", status, 4'b1000);

    // MOVS sets Z, preserving C/V; then NE ADD is squashed
    send(AL, MOV, 1, 0, 0, 1, 4'b0100);
    cyc();
    chk("movs_status", status, 4'b0100);
    send(NE, ADD, 1, 0, 0, 1, 4'b1111);
    chk("ne_exec", exec_command, 4'b0000);
    chk("ne_wb", {3'b0, wb_en}, 4'd0);
    cyc();
    chk("ne_status", status, 4'b0100);

    // CMP without S still updates flags, no write-back
    send(AL, CMP, 0, 0, 0, 1, 4'b0110);
    chk("cmp_wb", {3'b0, wb_en}, 4'd0);
    chk("cmp_exec", exec_command, 4'b0100);
    cyc();
    chk("cmp_status", status, 4'b0110);

    // LDR: adder command, write-back, no flag update even with S set
    send(AL, MOV, 1, 1, 0, 1, 4'b1111);
    chk("ldr_exec", exec_command, 4'b0010);
    chk("ldr_wb", {3'b0, wb_en}, 4'd1);
    chk("ldr_mem_r", {3'b0, mem_r_en}, 4'd1);
    cyc();
    chk("ldr_status", status, 4'b0110);

    // stall for 3 cycles in HOLD, then exactly one update
    send(AL, ADD, 1, 0, 0, 0, 4'b0001);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_in_ready", {3'b0, in_ready}, 4'd0);
      chk("hold_exec", exec_command, 4'b0010);
      chk("hold_status", status, 4'b0110);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("hold_upd", status, 4'b0001);
    cyc();
    chk("hold_once", status, 4'b0001);

    // ADDS then back-to-back ADC sees the new carry
    send(AL, ADD, 1, 0, 0, 1, 4'b0010);
    in_valid = 1'b1; opcode = ADC; s_bit = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk("b2b_carry", {3'b0, carry_in}, 4'd1);
    chk("b2b_exec", exec_command, 4'b0011);
    cyc();

    // ANDS keeps C and V
    send(AL, ADD, 1, 0, 0, 1, 4'b0011);
    cyc();
    send(AL, AND_OP, 1, 0, 0, 1, 4'b1000);
    cyc();
    chk("ands_status", status, 4'b1011);

    // flush while holding drops the instruction, no update
    send(AL, SUB, 1, 0, 0, 0, 4'b0100);
    cyc();
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", {3'b0, in_ready}, 4'd0);
    cyc();
    flush = 1'b0;
    chk("flush_valid", {3'b0, out_valid}, 4'd0);
    chk("flush_status", status, 4'b1011);

    // reset in the middle of a held instruction
    send(AL, ADD, 1, 0, 0, 0, 4'b1111);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("midrst_status", status, 4'b0000);
    chk("midrst_valid", {3'b0, out_valid}, 4'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      cond      = 4'($urandom_range(0, 15));
      opcode    = 4'($urandom_range(0, 15));
      s_bit     = 1'($urandom_range(0, 1));
      mem_r_in  = ($urandom_range(0, 7) == 0);
      mem_w_in  = ($urandom_range(0, 7) == 0);
      {alu_n, alu_z, alu_c, alu_v} = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
